// File: rtl/stage_writeback.sv
// Write-back stage: commits results to RAM or queues them for output devices.
// Define STAGE_WB_FWD_EN to expose the RAM write on fwd_* for fetch bypass.
module stage_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mblock_s3,
  input  logic [7:0]       vr_dest,
  input  logic [31:0]      vr_value,
  output logic             ram_we,
  output logic [15:0]      ram_address,
  output logic [31:0]      ram_value,
  output logic             output_devices_valid,
  input  logic             output_devices_ready,
  output logic [7:0]       output_devices_address,
  output logic [31:0]      output_devices_value,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fwd_valid,
  output logic [15:0]      fwd_address,
  output logic [31:0]      fwd_value
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]       r_fa [FIFO_DEPTH];
  logic [31:0]      r_fv [FIFO_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CNT_W-1:0] r_count;
  logic             r_ram_we;
  logic [15:0]      r_ram_address;
  logic [31:0]      r_ram_value;

  logic w_full;
  logic w_acc;
  logic w_push;
  logic w_pop;
  logic w_ram;

  // Full blocks only device writes; a same-cycle pop does not make room.
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign in_ready = !((mblock_s3 == 2'd2) && w_full);
  assign w_acc    = in_valid && in_ready;
  assign w_ram    = w_acc && (mblock_s3 == 2'd0);
  assign w_push   = w_acc && (mblock_s3 == 2'd2);
  assign w_pop    = output_devices_valid && output_devices_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ram_we      <= 1'b0;
      r_ram_address <= 16'h0000;
      r_ram_value   <= 32'h0;
    end else begin
      r_ram_we <= w_ram;
      if (w_ram) begin
        r_ram_address <= {8'h00, vr_dest};
        r_ram_value   <= vr_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fa[i] <= 8'h00;
        r_fv[i] <= 32'h0;
      end
    end else begin
      if (w_push) begin
        r_fa[r_wp] <= vr_dest;
        r_fv[r_wp] <= vr_value;
        r_wp       <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ram_we                 = r_ram_we;
  assign ram_address            = r_ram_address;
  assign ram_value              = r_ram_value;
  assign fifo_count             = r_count;
  assign output_devices_valid   = (r_count != '0);
  assign output_devices_address = r_fa[r_rp];
  assign output_devices_value   = r_fv[r_rp];

`ifdef STAGE_WB_FWD_EN
  assign fwd_valid   = r_ram_we;
  assign fwd_address = r_ram_we ? r_ram_address : 16'h0000;
  assign fwd_value   = r_ram_we ? r_ram_value : 32'h0;
`else
  assign fwd_valid   = 1'b0;
  assign fwd_address = 16'h0000;
  assign fwd_value   = 32'h0;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Scoreboard bench for stage_writeback: driver queues expectations,
// a negedge monitor pops them as RAM strobes and device pops appear.
module tb_stage_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mblock_s3;
  logic [7:0]  vr_dest;
  logic [31:0] vr_value;
  logic        ram_we;
  logic [15:0] ram_address;
  logic [31:0] ram_value;
  logic        odv;
  logic        odr;
  logic [7:0]  oda;
  logic [31:0] odd;
  logic [2:0]  fifo_count;
  logic        fwd_valid;
  logic [15:0] fwd_address;
  logic [31:0] fwd_value;

  stage_writeback #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mblock_s3(mblock_s3),
    .vr_dest(vr_dest),
    .vr_value(vr_value),
    .ram_we(ram_we),
    .ram_address(ram_address),
    .ram_value(ram_value),
    .output_devices_valid(odv),
    .output_devices_ready(odr),
    .output_devices_address(oda),
    .output_devices_value(odd),
    .fifo_count(fifo_count),
    .fwd_valid(fwd_valid),
    .fwd_address(fwd_address),
    .fwd_value(fwd_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mcount = 0;
  bit mon_en = 1'b0;
  logic [47:0] ram_q[$];
  logic [39:0] dev_q[$];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_we) begin
        if (ram_q.size() == 0) begin
          chk("ram_spurious_we", 64'(ram_we), 64'd0);
        end else begin
          chk("ram_write", {16'h0, ram_address, ram_value},
              {16'h0, ram_q.pop_front()});
        end
      end
`ifdef STAGE_WB_FWD_EN
      chk("fwd_valid", 64'(fwd_valid), 64'(ram_we));
`else
      chk("fwd_tied", {15'h0, fwd_valid, fwd_address, fwd_value}, 64'd0);
`endif
      if (odv && odr) begin
        if (dev_q.size() == 0) begin
          chk("dev_spurious_pop", 64'(odv), 64'd0);
        end else begin
          chk("dev_head", {24'h0, oda, odd}, {24'h0, dev_q.pop_front()});
          mcount--;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] s, input logic [7:0] d,
                       input logic [31:0] v);
    logic er;
    in_valid  = 1'b1;
    mblock_s3 = s;
    vr_dest   = d;
    vr_value  = v;
    #1;
    er = !((s == 2'd2) && (mcount == DEPTH));
    chk("in_ready", 64'(in_ready), 64'(er));
    if (er && s == 2'd0) ram_q.push_back({8'h00, d, v});
    if (er && s == 2'd2) begin
      dev_q.push_back({d, v});
      mcount++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    odr = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      if (dev_q.size() == 0) done = 1'b1;
    end
    #1;
    odr = 1'b0;
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    mblock_s3 = 2'd0;
    vr_dest   = 8'h00;
    vr_value  = 32'h0;
    odr       = 1'b0;
    @(negedge clk);
    chk("rst_ram", {15'h0, ram_we, ram_address, ram_value}, 64'd0);
    chk("rst_dev", {23'h0, odv, oda, odd}, 64'd0);
    chk("rst_cnt", 64'(fifo_count), 64'd0);
    chk("rst_fwd", {15'h0, fwd_valid, fwd_address, fwd_value}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // single RAM write, latency 1, strobe one cycle
    issue(2'd0, 8'h2A, 32'hDEADBEEF);
    @(negedge clk);
    chk("ram_we_hi", {15'h0, ram_we, ram_address, ram_value},
        {15'h0, 1'b1, 16'h002A, 32'hDEADBEEF});
    @(negedge clk);
    chk("ram_we_lo", 64'(ram_we), 64'd0);
    chk("ram_hold", {ram_address, ram_value}, {16'h002A, 32'hDEADBEEF});
    @(posedge clk);
    #1;

    // back-to-back RAM writes
    issue(2'd0, 8'h01, 32'h1111_0001);
    issue(2'd0, 8'hFF, 32'h2222_0002);

    // forwarding
    issue(2'd0, 8'h10, 32'd5);
    @(negedge clk);
`ifdef STAGE_WB_FWD_EN
    chk("fwd_hit", {15'h0, fwd_valid, fwd_address, fwd_value},
        {15'h0, 1'b1, 16'h0010, 32'd5});
`else
    chk("fwd_off", {15'h0, fwd_valid, fwd_address, fwd_value}, 64'd0);
`endif
    @(posedge clk);
    #1;

    // discard codes
    issue(2'd1, 8'h33, 32'hBAD0_0001);
    issue(2'd3, 8'h44, 32'hBAD0_0003);
    @(negedge clk);
    chk("discard_cnt", 64'(fifo_count), 64'd0);
    chk("discard_we", 64'(ram_we), 64'd0);
    @(posedge clk);
    #1;

    // backpressure: fill, check full, drain in order
    for (int i = 1; i <= 4; i++) issue(2'd2, 8'(i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    chk("full_cnt", 64'(fifo_count), 64'd4);
    chk("full_valid", 64'(odv), 64'd1);
    mblock_s3 = 2'd2;
    #1;
    chk("full_rdy_dev", 64'(in_ready), 64'd0);
    mblock_s3 = 2'd0;
    #1;
    chk("full_rdy_ram", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(2'd2, 8'h99, 32'h9999_9999);
    // full with pop in same cycle: no pass-through
    odr = 1'b1;
    issue(2'd2, 8'h98, 32'h9898_9898);
    drain();
    @(negedge clk);
    chk("drained_cnt", 64'(fifo_count), 64'd0);
    chk("drained_valid", 64'(odv), 64'd0);
    @(posedge clk);
    #1;

    // simultaneous push and pop at count=2
    issue(2'd2, 8'h51, 32'h5100_0001);
    issue(2'd2, 8'h52, 32'h5200_0002);
    odr = 1'b1;
    issue(2'd2, 8'h53, 32'h5300_0003);
    odr = 1'b0;
    @(negedge clk);
    chk("sim_cnt", 64'(fifo_count), 64'd2);
    chk("sim_head", {oda, odd}, {8'h52, 32'h5200_0002});
    @(posedge clk);
    #1;
    drain();

    // reset mid-operation with a RAM write in flight
    for (int i = 0; i < 3; i++) issue(2'd2, 8'h60 + 8'(i), 32'(i));
    @(negedge clk);
    chk("pre_rst_cnt", 64'(fifo_count), 64'd3);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    mblock_s3 = 2'd0;
    vr_dest   = 8'h77;
    vr_value  = 32'h7777_7777;
    dev_q.delete();
    mcount = 0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_cnt", 64'(fifo_count), 64'd0);
    chk("mid_rst_valid", 64'(odv), 64'd0);
    chk("mid_rst_we", 64'(ram_we), 64'd0);
    repeat (2) @(negedge clk);

    chk("ram_q_empty", 64'(ram_q.size()), 64'd0);
    chk("dev_q_empty", 64'(dev_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
